// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable CPU clock divider.
// The master side drives the divide/halt/step controls; the slave is the divider.
interface clk_div_prog_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             halt_req;
    logic             step;
    logic             CPUCLK;
    logic             cpu_tick;
    logic             halted;

    modport master (
        output div_in, div_load, halt_req, step,
        input  CPUCLK, cpu_tick, halted
    );

    modport slave (
        input  div_in, div_load, halt_req, step,
        output CPUCLK, cpu_tick, halted
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable CPU clock divider with glitch-free halt and single-step control.
// CPUCLK toggles only when the half-period counter reaches the active divide value.
module clk_div_prog #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_DIV  = 24,
    parameter bit START_HALTED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_prog_if.slave ifc
);
    typedef enum logic [1:0] {RUN, STOPPING, HALTED, STEP} state_t;

    localparam state_t           RST_STATE = START_HALTED ? HALTED : RUN;
    localparam logic [WIDTH-1:0] DIV_RST   = WIDTH'(DEFAULT_DIV);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, r_div, r_pend;
    logic             r_pend_vld, r_clk, r_tick;
    logic             w_run_halt, w_wrap, w_fall, w_apply, w_park;

    // Halting from a low phase cancels any wrap that would otherwise start a high phase.
    assign w_run_halt = (r_state == RUN) && ifc.halt_req && !r_clk;
    assign w_wrap     = (r_state != HALTED) && !w_run_halt && (r_cnt == r_div);
    assign w_fall     = w_wrap && r_clk;
    assign w_apply    = r_pend_vld && (w_wrap || (r_state == HALTED));
    assign w_park     = (r_state == HALTED) || (w_state_nxt == HALTED);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (ifc.halt_req)
                    w_state_nxt = (!r_clk || w_fall) ? HALTED : STOPPING;
            end
            STOPPING: begin
                if (!ifc.halt_req)
                    w_state_nxt = RUN;
                else if (w_fall)
                    w_state_nxt = HALTED;
            end
            HALTED: begin
                if (!ifc.halt_req)
                    w_state_nxt = RUN;
                else if (ifc.step)
                    w_state_nxt = STEP;
            end
            STEP: begin
                if (w_fall)
                    w_state_nxt = HALTED;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RST_STATE;
            r_cnt      <= '0;
            r_div      <= DIV_RST;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Counter sits at zero while parked so a resume starts a full low phase.
            if (w_park) begin
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (w_wrap) begin
                r_cnt  <= '0;
                r_clk  <= !r_clk;
                r_tick <= !r_clk;
            end else begin
                r_cnt  <= r_cnt + WIDTH'(1);
                r_tick <= 1'b0;
            end

            if (ifc.div_load) begin
                r_pend     <= ifc.div_in;
                r_pend_vld <= 1'b1;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end

            if (w_apply)
                r_div <= r_pend;
        end
    end

    assign ifc.CPUCLK   = r_clk;
    assign ifc.cpu_tick = r_tick;
    assign ifc.halted   = (r_state == HALTED);
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: phase lengths, divide reload, halt, step and reset.
// Two instances: default build and a START_HALTED build.
module tb_clk_div_prog;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    clk_div_prog_if #(.WIDTH(16)) ifc0();
    clk_div_prog_if #(.WIDTH(16)) ifc1();

    clk_div_prog #(.WIDTH(16), .DEFAULT_DIV(24), .START_HALTED(1'b0)) u0 (
        .clk (clk),
        .rst (rst),
        .ifc (ifc0)
    );

    clk_div_prog #(.WIDTH(16), .DEFAULT_DIV(24), .START_HALTED(1'b1)) u1 (
        .clk (clk),
        .rst (rst),
        .ifc (ifc1)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Counts consecutive negedge samples with CPUCLK == v, starting at the current sample.
    task automatic phase_len(input logic v, output int n, output int t);
        n = 0;
        t = 0;
        while (ifc0.CPUCLK === v && n < 2000) begin
            n++;
            t += int'(ifc0.cpu_tick);
            @(negedge clk);
        end
    endtask

    task automatic sync_rise();
        int n, t;
        phase_len(1'b1, n, t);
        phase_len(1'b0, n, t);
    endtask

    task automatic load_div(input logic [15:0] d);
        ifc0.div_in   = d;
        ifc0.div_load = 1'b1;
        @(negedge clk);
        ifc0.div_load = 1'b0;
    endtask

    initial begin
        int n, t, h, bad, w;
        logic [7:0]  cv8, tv8;
        logic [19:0] cv, hv;

        checks = 0;
        failures = 0;
        clk = 1'b0;
        rst = 1'b0;
        ifc0.div_in = '0; ifc0.div_load = 1'b0; ifc0.halt_req = 1'b0; ifc0.step = 1'b0;
        ifc1.div_in = '0; ifc1.div_load = 1'b0; ifc1.halt_req = 1'b1; ifc1.step = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_clk", ifc0.CPUCLK, 0);
        chk("rst_tick", ifc0.cpu_tick, 0);
        chk("rst_halted", ifc0.halted, 0);
        chk("rst_halted_sh", ifc1.halted, 1);
        chk("rst_clk_sh", ifc1.CPUCLK, 0);
        rst = 1'b1;

        // Default divide: 25 cycles per phase, one tick per period
        phase_len(1'b0, n, t); chk("first_low", n, 25);
        phase_len(1'b1, n, t); chk("high_def", n, 25);
        chk("tick_def", t, 1);
        phase_len(1'b0, n, t); chk("low_def", n, 25);

        // Load 3 mid-high-phase: current phase still completes at 25
        h = 0;
        repeat (5) begin h += int'(ifc0.CPUCLK); @(negedge clk); end
        h += int'(ifc0.CPUCLK);
        load_div(16'd3);
        phase_len(1'b1, n, t); chk("high_span_load", h + n, 25);
        phase_len(1'b0, n, t); chk("low_div3", n, 4);
        phase_len(1'b1, n, t); chk("high_div3", n, 4);
        chk("tick_div3", t, 1);
        phase_len(1'b0, n, t); chk("low_div3b", n, 4);

        // Load 0: toggle every clk, tick every other cycle
        h = int'(ifc0.CPUCLK);
        load_div(16'd0);
        phase_len(1'b1, n, t); chk("high_span_load0", h + n, 4);
        for (int i = 0; i < 8; i++) begin
            cv8[i] = ifc0.CPUCLK;
            tv8[i] = ifc0.cpu_tick;
            @(negedge clk);
        end
        chk("div0_clk", cv8, 8'hAA);
        chk("div0_tick", tv8, 8'hAA);

        // Halt while high: phase completes, then held low
        load_div(16'd3);
        sync_rise();
        sync_rise();
        ifc0.halt_req = 1'b1;
        phase_len(1'b1, n, t); chk("stop_high", n, 4);
        chk("halt_clk0", ifc0.CPUCLK, 0);
        chk("halted", ifc0.halted, 1);
        bad = 0;
        repeat (200) begin
            if (ifc0.CPUCLK !== 1'b0 || ifc0.halted !== 1'b1 || ifc0.cpu_tick !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("hold200", bad, 0);

        // Three single steps; a step during STEP is ignored
        for (int k = 0; k < 3; k++) begin
            ifc0.step = 1'b1;
            @(negedge clk);
            ifc0.step = 1'b0;
            t = 0;
            for (int i = 0; i < 20; i++) begin
                cv[i] = ifc0.CPUCLK;
                hv[i] = ifc0.halted;
                t += int'(ifc0.cpu_tick);
                ifc0.step = (k == 1 && i == 2);
                @(negedge clk);
            end
            ifc0.step = 1'b0;
            chk($sformatf("step%0d_clk", k), cv, 20'h000F0);
            chk($sformatf("step%0d_halted", k), hv, 20'hFFF00);
            chk($sformatf("step%0d_tick", k), t, 1);
        end

        // Resume: one halted sample plus a full div+1 low phase
        ifc0.halt_req = 1'b0;
        phase_len(1'b0, n, t); chk("resume_low", n, 5);
        chk("resume_halted", ifc0.halted, 0);

        // Halt request withdrawn during STOPPING leaves the phase untouched
        ifc0.halt_req = 1'b1;
        h = int'(ifc0.CPUCLK);
        @(negedge clk);
        h += int'(ifc0.CPUCLK);
        @(negedge clk);
        ifc0.halt_req = 1'b0;
        phase_len(1'b1, n, t); chk("stop_cancel_high", h + n, 4);
        phase_len(1'b0, n, t); chk("stop_cancel_low", n, 4);

        // Reset during STEP with a pending divide
        ifc0.halt_req = 1'b1;
        w = 0;
        while (ifc0.halted !== 1'b1 && w < 100) begin w++; @(negedge clk); end
        chk("halt_again", ifc0.halted, 1);
        ifc0.step = 1'b1;
        @(negedge clk);
        ifc0.step = 1'b0;
        repeat (4) @(negedge clk);
        chk("step_high", ifc0.CPUCLK, 1);
        load_div(16'd5);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_clk", ifc0.CPUCLK, 0);
        chk("arst_tick", ifc0.cpu_tick, 0);
        chk("arst_halted", ifc0.halted, 0);
        chk("arst_halted_sh", ifc1.halted, 1);
        ifc0.halt_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        phase_len(1'b0, n, t); chk("post_rst_low", n, 25);
        phase_len(1'b1, n, t); chk("post_rst_high", n, 25);

        // START_HALTED build stays parked until halt_req drops
        bad = 0;
        repeat (10) begin
            if (ifc1.halted !== 1'b1 || ifc1.CPUCLK !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("sh_hold", bad, 0);
        ifc1.halt_req = 1'b0;
        n = 0;
        while (ifc1.CPUCLK === 1'b0 && n < 200) begin n++; @(negedge clk); end
        chk("sh_first_rise", n, 26);
        chk("sh_run_halted", ifc1.halted, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, bit width of divide register and counter.
REQ-002 SHALL provide parameter DEFAULT_DIV, default 24, half-period terminal count loaded at reset.
REQ-003 SHALL provide parameter START_HALTED, default 0, selects HALTED (1) or RUN (0) as the reset state.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 div_in  input  WIDTH  new half-period terminal count.
REQ-007 div_load  input  1  one-cycle strobe capturing div_in.
REQ-008 halt_req  input  1  level; request CPU clock stop.
REQ-009 step  input  1  one-cycle strobe; request one CPU clock period while halted.
REQ-010 CPUCLK  output  1  divided CPU clock, registered.
REQ-011 cpu_tick  output  1  one-cycle pulse, high in the first clk cycle of each CPUCLK high phase.
REQ-012 halted  output  1  high while in HALTED.

Function
REQ-013 States SHALL be RUN, STOPPING, HALTED, STEP.
REQ-014 In RUN, STOPPING and STEP, counter SHALL increment each cycle; when counter == div_reg, the counter SHALL clear to 0 and CPUCLK SHALL toggle (wrap event).
REQ-015 CPUCLK period SHALL be 2*(div_reg+1) clk cycles; div_reg = 0 gives clk/2.
REQ-016 cpu_tick SHALL be 1 exactly in cycles where CPUCLK is 1 and was 0 in the previous cycle; otherwise 0.
REQ-017 div_load SHALL store div_in into a pending register and set a pending flag; a later div_load before application overwrites the pending value.
REQ-018 Pending value SHALL be copied to div_reg at the next wrap event, or immediately on the next cycle while HALTED; the flag then clears.
REQ-019 The counter SHALL never exceed div_reg; no mid-phase truncation or extension on div change.
REQ-020 RUN with halt_req=1: if CPUCLK=0, go to HALTED next cycle; if CPUCLK=1, go to STOPPING.
REQ-021 STOPPING SHALL keep counting; at the wrap that drives CPUCLK 1->0, go to HALTED. halt_req deassert in STOPPING SHALL return to RUN without disturbing the counter.
REQ-022 HALTED SHALL hold CPUCLK=0, counter=0, cpu_tick=0, halted=1.
REQ-023 HALTED with halt_req=0 SHALL go to RUN; the first rising CPUCLK occurs div_reg+1 cycles after entering RUN.
REQ-024 HALTED with halt_req=1 and step=1 SHALL go to STEP; step with halt_req=0 or outside HALTED SHALL be ignored.
REQ-025 STEP SHALL produce exactly one low phase and one high phase (div_reg+1 cycles each), then return to HALTED at the 1->0 wrap, regardless of halt_req.
REQ-026 CPUCLK SHALL be glitch-free: only toggles at wrap events; no high phase shorter than div_reg+1 cycles.

Reset
REQ-027 On rst=0, asynchronously: CPUCLK=0, cpu_tick=0, counter=0, div_reg=DEFAULT_DIV, pending flag=0, state=RUN (HALTED if START_HALTED=1), halted accordingly.
REQ-028 Reset asserted mid-phase or mid-step SHALL abort immediately to reset values; pending div SHALL be discarded.

Verification
REQ-029 T=20 ns, defaults, release rst at 10 ns -> CPUCLK period 1000 ns, 50% duty, cpu_tick one clk wide per period.
REQ-030 div_load with div_in=3 mid-high-phase -> current phase completes at 25 cycles, then period 8 cycles thereafter.
REQ-031 div_in=0 loaded -> CPUCLK toggles every clk; cpu_tick high every other cycle.
REQ-032 halt_req=1 while CPUCLK=1 -> high phase completes, CPUCLK falls, halted=1 next cycle; held low for 200 cycles.
REQ-033 Halted, div=3, three step pulses spaced 20 cycles -> exactly three CPUCLK pulses, each 4 cycles high after 4 low, halted=1 between; step during STEP ignored.
REQ-034 rst pulsed low during STEP -> outputs reset within the same cycle; START_HALTED=1 build -> halted=1, CPUCLK=0 after reset until halt_req=0.
